// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32x32 multiply / divide unit that owns the
// architectural HI/LO registers. MULT/MULTU/DIV/DIVU take 33 cycles from
// the accepting edge to the HI/LO update; MTHI/MTLO complete in one edge.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic        is_div;     // current operation is DIV/DIVU
  logic        neg_res;    // negate product / quotient at FINISH
  logic        neg_rem;    // negate remainder at FINISH
  logic        div_zero;   // divisor was zero
  logic [31:0] a_orig;     // original dividend, returned in HI on divide-by-zero
  logic [31:0] opnd;       // multiplicand (multiply) or divisor (divide) magnitude
  logic [63:0] p;          // multiply: {partial product, multiplier}; divide: {remainder, quotient}

  logic        is_signed_op;
  logic        accept_md;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] p_step;

  assign busy = (state != IDLE);

  // Operand magnitudes and one multiply or divide iteration.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    is_signed_op = ~op[0];
    accept_md    = start && (state == IDLE) && !op[2];
    a_mag        = (is_signed_op && a[31]) ? -a : a;
    b_mag        = (is_signed_op && b[31]) ? -b : b;
    mul_sum      = {1'b0, p[63:32]} + (p[0] ? {1'b0, opnd} : 33'd0);
    div_shift    = {p[63:32], p[31]};
    div_diff     = div_shift - {1'b0, opnd};
    p_step       = {mul_sum, p[31:1]};
    if (is_div) begin
      // Restoring step: keep the difference only when it did not borrow.
      p_step = div_diff[32] ? {div_shift[31:0], p[30:0], 1'b0}
                            : {div_diff[31:0],  p[30:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is sampled like any other input on the clock edge.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_md) state_nxt = RUN;
      RUN:     if (cnt == 6'd31) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, sign fix-up and HI/LO writes.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (reset) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_orig   <= '0;
      opnd     <= '0;
      p        <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_md) begin
            cnt      <= '0;
            is_div   <= op[1];
            neg_res  <= is_signed_op && (a[31] ^ b[31]);
            neg_rem  <= is_signed_op && a[31];
            div_zero <= (b == 32'd0);
            a_orig   <= a;
            opnd     <= op[1] ? b_mag : a_mag;
            p        <= {32'd0, (op[1] ? a_mag : b_mag)};
          end else if (start && op == OP_MTHI) begin
            hi <= a;
          end else if (start && op == OP_MTLO) begin
            lo <= a;
          end
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          p   <= p_step;
        end
        FINISH: begin
          done <= 1'b1;
          if (!is_div) begin
            {hi, lo} <= neg_res ? -p : p;
          end else if (div_zero) begin
            hi <= a_orig;
            lo <= 32'hFFFF_FFFF;
          end else begin
            lo <= neg_res ? -p[31:0]  : p[31:0];
            hi <= neg_rem ? -p[63:32] : p[63:32];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases, randomized
// operations against an arithmetic reference model, back-to-back issue,
// no-op handling, MTHI/MTLO, start-while-busy and reset mid-operation.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x, y, eh, el;
  } vec_t;

  // Reference result {hi, lo} computed with plain integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, sp, sq, sr;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    case (o)
      3'd0: begin sp = sx * sy; r = sp; end
      3'd1: r = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else begin sq = sx / sy; sr = sx % sy; r = {sr[31:0], sq[31:0]}; end
      end
      3'd3: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one MULT/DIV-class op (called at a negedge) and observe it until done.
  task automatic issue_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcnt, output logic early,
                          output logic [31:0] rh, output logic [31:0] rl);
    logic [31:0] oh, ol;
    oh = hi; ol = lo; early = 1'b0; lat = -1; bcnt = 0; rh = 'x; rl = 'x;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin lat = i - 1; rh = hi; rl = lo; break; end
      if (hi !== oh || lo !== ol) early = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 00000000", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 00000000", lo); end
  endtask

  task automatic test_directed();
    vec_t v[6];
    int lat, bcnt;
    logic early;
    logic [31:0] rh, rl;
    v[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    v[1] = '{3'd0, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1};
    v[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    v[3] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    v[4] = '{3'd3, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF};
    v[5] = '{3'd2, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b exp 0", i, done); end
      issue_md(v[i].o, v[i].x, v[i].y, lat, bcnt, early, rh, rl);
      checks++; if (lat !== 33) begin errors++; $display("FAIL dir%0d_latency got %0d exp 33", i, lat); end
      checks++; if (bcnt !== 33) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d exp 33", i, bcnt); end
      checks++; if (early !== 1'b0) begin errors++; $display("FAIL dir%0d_early_update got %b exp 0", i, early); end
      checks++; if (rh !== v[i].eh) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, rh, v[i].eh); end
      checks++; if (rl !== v[i].el) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, rl, v[i].el); end
    end
  endtask

  task automatic test_random();
    int lat, bcnt;
    logic early;
    logic [31:0] rh, rl, x, y;
    logic [2:0] o;
    logic [63:0] exp_r;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3)); x = pick(); y = pick();
      exp_r = ref_md(o, x, y);
      @(negedge clk);
      issue_md(o, x, y, lat, bcnt, early, rh, rl);
      checks++; if (lat !== 33) begin errors++; $display("FAIL rnd%0d_latency op %0d got %0d exp 33", i, o, lat); end
      checks++; if (rh !== exp_r[63:32]) begin errors++; $display("FAIL rnd%0d_hi op %0d a %h b %h got %h exp %h", i, o, x, y, rh, exp_r[63:32]); end
      checks++; if (rl !== exp_r[31:0]) begin errors++; $display("FAIL rnd%0d_lo op %0d a %h b %h got %h exp %h", i, o, x, y, rl, exp_r[31:0]); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt;
    logic early;
    logic [31:0] rh, rl, x1, y1, x2, y2;
    logic [63:0] e1, e2;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = 32'($urandom_range(1, 1000));
    e1 = ref_md(3'd0, x1, y1);
    e2 = ref_md(3'd2, x2, y2);
    @(negedge clk);
    issue_md(3'd0, x1, y1, lat, bcnt, early, rh, rl);
    checks++; if ({rh, rl} !== e1) begin errors++; $display("FAIL b2b_first got %h exp %h", {rh, rl}, e1); end
    // Still in the done cycle: the second start is presented immediately.
    issue_md(3'd2, x2, y2, lat, bcnt, early, rh, rl);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_second_latency got %0d exp 33", lat); end
    checks++; if ({rh, rl} !== e2) begin errors++; $display("FAIL b2b_second got %h exp %h", {rh, rl}, e2); end
  endtask

  task automatic test_noop();
    logic [31:0] h, l;
    h = $urandom; l = $urandom;
    @(negedge clk); start = 1'b1; op = 3'b100; a = h;
    @(negedge clk); op = 3'b101; a = l;
    for (int i = 6; i < 8; i++) begin
      @(negedge clk); op = 3'(i); a = $urandom; b = $urandom;
    end
    @(negedge clk); start = 1'b0;
    checks++; if (hi !== h) begin errors++; $display("FAIL noop_hi got %h exp %h", hi, h); end
    checks++; if (lo !== l) begin errors++; $display("FAIL noop_lo got %h exp %h", lo, l); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL noop_busy_done got %b%b exp 00", busy, done); end
  endtask

  task automatic test_control();
    logic seen_done;
    seen_done = 1'b0;
    // MTHI from idle: visible right after the accepting edge, no busy/done.
    @(negedge clk); start = 1'b1; op = 3'b100; a = 32'h1234_5678;
    @(posedge clk); #1 start = 1'b0;
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi_hi got %h exp 12345678", hi); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_busy_done got %b%b exp 00", busy, done); end
    // MULTU 3x4 with an MTLO presented mid-operation, which must be ignored.
    start = 1'b1; op = 3'b001; a = 32'd3; b = 32'd4;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'h0000_DEAD;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin seen_done = 1'b1; break; end
    end
    checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL ctl_multu_done got 0 exp 1"); end
    checks++; if (lo !== 32'h0000_000C) begin errors++; $display("FAIL ctl_multu_lo got %h exp 0000000c", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL ctl_multu_hi got %h exp 00000000", hi); end
    // DIVU interrupted by reset: result discarded, no done pulse.
    @(negedge clk); start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ctl_reset_busy got %b exp 0", busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL ctl_reset_hilo got %h %h exp 0 0", hi, lo); end
    seen_done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL ctl_reset_no_done got 1 exp 0"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_noop();
    test_control();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
